// File: rtl/setting_mode_fsm.sv
// Setting-mode controller: long press in standby enters, short press cycles items, long press commits.
// Optional idle-timeout abort is compiled in with `define SETTING_TIMEOUT_EN.
module setting_mode_fsm #(
  parameter int unsigned MODE_WIDTH    = 3,
  parameter int unsigned STAND_CODE    = 0,
  parameter int unsigned NUM_ITEMS     = 4,
  parameter int unsigned HOLD_TICKS    = 3000,
  parameter int unsigned TIMEOUT_TICKS = 10000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MODE_WIDTH-1:0]        current_mode,
  input  logic                         tick,
  input  logic                         key,
  output logic                         setting_active,
  output logic [$clog2(NUM_ITEMS)-1:0] item_idx,
  output logic                         setting_enter,
  output logic                         item_advance,
  output logic                         setting_commit,
  output logic                         setting_abort
);

  localparam int unsigned IDX_W  = $clog2(NUM_ITEMS);
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS);

  if (NUM_ITEMS < 2 || HOLD_TICKS < 2 || TIMEOUT_TICKS < 2) begin : g_param_check
    $error("setting_mode_fsm: NUM_ITEMS, HOLD_TICKS and TIMEOUT_TICKS must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SETTING,
    S_HELD,
    S_WAIT_REL
  } state_t;

  state_t            state, state_nxt;
  logic              key_q;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              post_commit, post_commit_nxt;
  logic [IDX_W-1:0]  item_nxt;
  logic              active_nxt;
  logic              enter_nxt, advance_nxt, commit_nxt, abort_nxt;

  logic key_rise, stand, hold_done;

`ifdef SETTING_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_TICKS);
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic              idle_done;
  assign idle_done = (idle_cnt == IDLE_W'(TIMEOUT_TICKS - 1));
`endif

  assign key_rise  = key & ~key_q;
  assign stand     = (current_mode == MODE_WIDTH'(STAND_CODE));
  assign hold_done = (hold_cnt == HOLD_W'(HOLD_TICKS - 1));

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      key_q          <= 1'b0;
      hold_cnt       <= '0;
      post_commit    <= 1'b0;
      setting_active <= 1'b0;
      item_idx       <= '0;
      setting_enter  <= 1'b0;
      item_advance   <= 1'b0;
      setting_commit <= 1'b0;
      setting_abort  <= 1'b0;
`ifdef SETTING_TIMEOUT_EN
      idle_cnt       <= '0;
`endif
    end else begin
      state          <= state_nxt;
      key_q          <= key;
      hold_cnt       <= hold_nxt;
      post_commit    <= post_commit_nxt;
      setting_active <= active_nxt;
      item_idx       <= item_nxt;
      setting_enter  <= enter_nxt;
      item_advance   <= advance_nxt;
      setting_commit <= commit_nxt;
      setting_abort  <= abort_nxt;
`ifdef SETTING_TIMEOUT_EN
      idle_cnt       <= idle_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    hold_nxt        = hold_cnt;
    post_commit_nxt = post_commit;
    active_nxt      = setting_active;
    item_nxt        = item_idx;
    enter_nxt       = 1'b0;
    advance_nxt     = 1'b0;
    commit_nxt      = 1'b0;
    abort_nxt       = 1'b0;
`ifdef SETTING_TIMEOUT_EN
    idle_nxt        = idle_cnt;
`endif

    case (state)
      S_IDLE: begin
        if (key_rise && stand) begin
          state_nxt = S_ARMED;
          hold_nxt  = '0;
        end
      end

      S_ARMED: begin
        if (!key || !stand) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          if (hold_done) begin
            enter_nxt       = 1'b1;
            active_nxt      = 1'b1;
            item_nxt        = '0;
            post_commit_nxt = 1'b0;
            state_nxt       = S_WAIT_REL;
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
      end

      // After a commit the mode no longer matters; only the release is awaited
      S_WAIT_REL: begin
        if (post_commit) begin
          if (!key) state_nxt = S_IDLE;
        end else if (!stand) begin
          abort_nxt = 1'b1;
        end else if (!key) begin
          state_nxt = S_SETTING;
`ifdef SETTING_TIMEOUT_EN
          idle_nxt  = '0;
`endif
        end
      end

      S_SETTING: begin
        if (!stand) begin
          abort_nxt = 1'b1;
        end else if (key_rise) begin
          state_nxt = S_HELD;
          hold_nxt  = '0;
`ifdef SETTING_TIMEOUT_EN
          idle_nxt  = '0;
`endif
        end
`ifdef SETTING_TIMEOUT_EN
        else if (tick && !key) begin
          if (idle_done) abort_nxt = 1'b1;
          else           idle_nxt  = idle_cnt + IDLE_W'(1);
        end
`endif
      end

      // Release beats the final hold tick; a mode change beats both
      S_HELD: begin
        if (!stand) begin
          abort_nxt = 1'b1;
        end else if (!key) begin
          advance_nxt = 1'b1;
          item_nxt    = (item_idx == IDX_W'(NUM_ITEMS - 1)) ? '0 : item_idx + IDX_W'(1);
          state_nxt   = S_SETTING;
`ifdef SETTING_TIMEOUT_EN
          idle_nxt    = '0;
`endif
        end else if (tick) begin
          if (hold_done) begin
            commit_nxt      = 1'b1;
            active_nxt      = 1'b0;
            post_commit_nxt = 1'b1;
            state_nxt       = S_WAIT_REL;
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    if (abort_nxt) begin
      active_nxt = 1'b0;
      state_nxt  = S_IDLE;
    end
  end

endmodule

// File: tb/tb_setting_mode_fsm.sv
// Bench for setting_mode_fsm: directed literal checks then random stimulus against a behavioural model.
module tb_setting_mode_fsm;

  localparam int MW = 3;
  localparam int N  = 4;
  localparam int H  = 4;
  localparam int T  = 6;
  localparam logic [MW-1:0] STAND_M = 3'd0;

  logic          clk;
  logic          rst, tick, key;
  logic [MW-1:0] current_mode;
  logic          setting_active;
  logic [1:0]    item_idx;
  logic          setting_enter, item_advance, setting_commit, setting_abort;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 0;

  setting_mode_fsm #(
    .MODE_WIDTH(MW), .STAND_CODE(0), .NUM_ITEMS(N), .HOLD_TICKS(H), .TIMEOUT_TICKS(T)
  ) dut (
    .clk(clk), .rst(rst), .current_mode(current_mode), .tick(tick), .key(key),
    .setting_active(setting_active), .item_idx(item_idx), .setting_enter(setting_enter),
    .item_advance(item_advance), .setting_commit(setting_commit), .setting_abort(setting_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: expected outputs after each clock edge
  bit m_keyq, m_arming, m_active, m_pressing, m_wait_enter, m_wait_commit;
  int m_press, m_idle, m_item;
  bit e_enter, e_adv, e_commit, e_abort;
  bit m_rise, m_stand;

  always @(posedge clk) begin
    e_enter = 0; e_adv = 0; e_commit = 0; e_abort = 0;
    if (rst) begin
      m_arming = 0; m_active = 0; m_pressing = 0; m_wait_enter = 0; m_wait_commit = 0;
      m_press = 0; m_idle = 0; m_item = 0; m_keyq = 0;
    end else begin
      m_rise  = key && !m_keyq;
      m_stand = (current_mode == STAND_M);
      if (m_wait_commit) begin
        if (!key) m_wait_commit = 0;
      end else if (m_active) begin
        if (!m_stand) begin
          e_abort = 1; m_active = 0; m_pressing = 0; m_wait_enter = 0;
        end else if (m_wait_enter) begin
          if (!key) begin m_wait_enter = 0; m_idle = 0; end
        end else if (m_pressing) begin
          if (!key) begin
            e_adv = 1; m_item = (m_item + 1) % N; m_pressing = 0; m_idle = 0;
          end else if (tick) begin
            if (m_press == H - 1) begin
              e_commit = 1; m_active = 0; m_pressing = 0; m_wait_commit = 1;
            end else m_press++;
          end
        end else if (m_rise) begin
          m_pressing = 1; m_press = 0; m_idle = 0;
        end
`ifdef SETTING_TIMEOUT_EN
        else if (tick && !key) begin
          if (m_idle == T - 1) begin e_abort = 1; m_active = 0; end
          else m_idle++;
        end
`endif
      end else if (m_arming) begin
        if (!key || !m_stand) m_arming = 0;
        else if (tick) begin
          if (m_press == H - 1) begin
            e_enter = 1; m_active = 1; m_item = 0; m_arming = 0; m_wait_enter = 1;
          end else m_press++;
        end
      end else if (m_rise && m_stand) begin
        m_arming = 1; m_press = 0;
      end
      m_keyq = key;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [6:0] got, exp;
    if (checking) begin
      got = {setting_active, item_idx, setting_enter, item_advance, setting_commit, setting_abort};
      exp = {m_active, 2'(m_item), e_enter, e_adv, e_commit, e_abort};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t: got act/idx/ent/adv/com/abt=%b expected %b", $time, got, exp);
      end
    end
  end

  task automatic cyc(input bit r, input bit k, input bit t, input logic [MW-1:0] m);
    rst = r; key = k; tick = t; current_mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic long_press();
    cyc(0, 1, 0, STAND_M);
    repeat (H) cyc(0, 1, 1, STAND_M);
  endtask

  int seq[5] = '{1, 2, 3, 0, 1};
  bit rk;
  logic [MW-1:0] rm;

  initial begin
    rst = 1; key = 0; tick = 0; current_mode = STAND_M;
    cyc(1, 0, 0, STAND_M);
    checking = 1;
    lit("reset_outputs", {setting_active, item_idx, setting_enter, item_advance, setting_commit, setting_abort}, 0);

    // Three-tick press is too short
    cyc(0, 1, 0, STAND_M);
    repeat (H - 1) cyc(0, 1, 1, STAND_M);
    lit("short_arm_enter", setting_enter, 0);
    lit("short_arm_active", setting_active, 0);
    cyc(0, 0, 0, STAND_M);

    long_press();
    lit("enter_pulse", setting_enter, 1);
    lit("enter_active", setting_active, 1);
    lit("enter_idx", item_idx, 0);
    cyc(0, 1, 0, STAND_M);
    lit("enter_one_cycle", setting_enter, 0);
    cyc(0, 0, 0, STAND_M);

    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, STAND_M);
      cyc(0, 1, 1, STAND_M);
      cyc(0, 0, 0, STAND_M);
      lit("short_press_adv", item_advance, 1);
      lit("short_press_idx", item_idx, seq[i]);
    end

    long_press();
    lit("commit_pulse", setting_commit, 1);
    lit("commit_inactive", setting_active, 0);
    lit("commit_idx_hold", item_idx, 1);
    repeat (5) cyc(0, 1, 1, STAND_M);
    lit("post_commit_no_enter", setting_active, 0);
    cyc(0, 0, 0, STAND_M);
    long_press();
    lit("reenter_pulse", setting_enter, 1);
    lit("reenter_idx", item_idx, 0);
    cyc(0, 0, 0, STAND_M);

    // Mode change coinciding with the final hold tick
    cyc(0, 1, 0, STAND_M);
    repeat (H - 1) cyc(0, 1, 1, STAND_M);
    cyc(0, 1, 1, 3'd2);
    lit("mode_abort", setting_abort, 1);
    lit("mode_no_commit", setting_commit, 0);
    lit("mode_inactive", setting_active, 0);
    cyc(0, 1, 0, STAND_M);
    lit("abort_no_rearm", setting_active + setting_abort, 0);
    cyc(0, 0, 0, STAND_M);

    // Reset while a press is held in setting mode
    long_press();
    cyc(0, 0, 0, STAND_M);
    cyc(0, 1, 0, STAND_M);
    cyc(0, 1, 1, STAND_M);
    cyc(1, 1, 0, STAND_M);
    lit("reset_mid_held", {setting_active, item_idx, setting_enter, item_advance, setting_commit, setting_abort}, 0);
    cyc(0, 0, 0, STAND_M);

    long_press();
    cyc(0, 0, 0, STAND_M);
`ifdef SETTING_TIMEOUT_EN
    repeat (4) cyc(0, 0, 1, STAND_M);
    cyc(0, 1, 0, STAND_M);
    cyc(0, 0, 0, STAND_M);
    repeat (T - 1) cyc(0, 0, 1, STAND_M);
    lit("timeout_restart", setting_active, 1);
    cyc(0, 0, 1, STAND_M);
    lit("timeout_abort", setting_abort, 1);
    lit("timeout_inactive", setting_active, 0);
`else
    repeat (100) cyc(0, 0, 1, STAND_M);
    lit("no_timeout_active", setting_active, 1);
    cyc(0, 0, 0, 3'd1);
    lit("exit_by_mode", setting_abort, 1);
`endif
    cyc(0, 0, 0, STAND_M);

    rk = 0; rm = STAND_M;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, rk ? 9 : 5) == 0) rk = !rk;
      if ($urandom_range(0, 39) == 0)
        rm = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : STAND_M;
      cyc(($urandom_range(0, 799) == 0), rk, ($urandom_range(0, 1) == 1), rm);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
